// File: rtl/ram_pkg.sv
// Shared definitions for the register-file RAM family: engine state encoding
// and the sizing rule for the sequential-initialisation counter.
package ram_pkg;

   typedef enum logic {
      RAM_INIT  = 1'b0,
      RAM_READY = 1'b1
   } ram_state_t;

   // The counter has to be able to hold DEPTH itself, hence the +1.
   function automatic int cnt_width(input int depth);
      return (depth < 1) ? 1 : $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/ram_mrmw_init_if.sv
// Read/write bus of the multi-port register-file RAM. The requester drives
// addresses, data and enables; the RAM returns read data, ready and conflict.
interface ram_mrmw_init_if #(
   parameter int NRD   = 2,
   parameter int NWR   = 2,
   parameter int INDEX = 4,
   parameter int WIDTH = 8
) ();

   logic [NRD-1:0][INDEX-1:0] raddr_i;
   logic [NRD-1:0][WIDTH-1:0] rdata_o;
   logic [NWR-1:0][INDEX-1:0] waddr_i;
   logic [NWR-1:0][WIDTH-1:0] wdata_i;
   logic [NWR-1:0]            we_i;
   logic                      ready_o;
   logic                      conflict_o;

   modport master (
      output raddr_i, waddr_i, wdata_i, we_i,
      input  rdata_o, ready_o, conflict_o
   );

   modport slave (
      input  raddr_i, waddr_i, wdata_i, we_i,
      output rdata_o, ready_o, conflict_o
   );

endinterface

// File: rtl/wr_port_arbiter.sv
// Resolves all write ports onto per-entry enable/data: the highest-numbered
// enabled port wins an entry, and any shared in-range address flags a conflict.
module wr_port_arbiter #(
   parameter int NWR   = 2,
   parameter int DEPTH = 16,
   parameter int INDEX = 4,
   parameter int WIDTH = 8
) (
   input  logic [NWR-1:0][INDEX-1:0]   waddr,
   input  logic [NWR-1:0][WIDTH-1:0]   wdata,
   input  logic [NWR-1:0]              we,
   output logic [DEPTH-1:0]            en,
   output logic [DEPTH-1:0][WIDTH-1:0] data,
   output logic                        conflict
);

   logic [NWR-1:0] valid;

   always_comb begin
      // NOTE: every output of a combinational block gets a default before any
      // conditional assignment; a path that leaves one unassigned infers a latch.
      valid    = '0;
      en       = '0;
      data     = '0;
      conflict = 1'b0;

      // Out-of-range writes are dropped here, so they never reach the array
      // and never take part in conflict detection.
      for (int p = 0; p < NWR; p++) begin
         valid[p] = we[p] && (int'(waddr[p]) < DEPTH);
      end

      // Ascending port order: a later port overrides, so the highest port wins.
      for (int a = 0; a < DEPTH; a++) begin
         for (int p = 0; p < NWR; p++) begin
            if (valid[p] && (waddr[p] == INDEX'(a))) begin
               en[a]   = 1'b1;
               data[a] = wdata[p];
            end
         end
      end

      for (int p = 0; p < NWR; p++) begin
         for (int q = p + 1; q < NWR; q++) begin
            if (valid[p] && valid[q] && (waddr[p] == waddr[q])) begin
               conflict = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/ram_mrmw_init.sv
// Multi-read / multi-write register-file RAM with deterministic write priority,
// optional write-to-read bypass and a one-entry-per-cycle initialisation engine.
module ram_mrmw_init
   import ram_pkg::*;
#(
   parameter int               NRD      = 2,
   parameter int               NWR      = 2,
   parameter int               DEPTH    = 16,
   parameter int               INDEX    = 4,
   parameter int               WIDTH    = 8,
   parameter int               BYPASS   = 0,
   parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
   input  logic      clk,
   input  logic      reset,
   ram_mrmw_init_if.slave bus
);

   localparam int CW = cnt_width(DEPTH);

   ram_state_t                 state_q;
   ram_state_t                 state_d;
   logic [CW-1:0]              cnt_q;
   logic [CW-1:0]              cnt_d;
   logic                       conflict_q;
   logic                       ready;
   logic [WIDTH-1:0]           ram [DEPTH];
   logic [NRD-1:0][WIDTH-1:0]  rdata;

   logic [DEPTH-1:0]            wr_en;
   logic [DEPTH-1:0][WIDTH-1:0] wr_data;
   logic                        wr_conflict;

   wr_port_arbiter #(
      .NWR   (NWR),
      .DEPTH (DEPTH),
      .INDEX (INDEX),
      .WIDTH (WIDTH)
   ) u_arb (
      .waddr    (bus.waddr_i),
      .wdata    (bus.wdata_i),
      .we       (bus.we_i),
      .en       (wr_en),
      .data     (wr_data),
      .conflict (wr_conflict)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         RAM_INIT: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(DEPTH - 1)) begin
               state_d = RAM_READY;
            end
         end
         RAM_READY: begin
            cnt_d = cnt_q;
         end
         default: state_d = RAM_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      if (reset) begin
         state_q    <= RAM_INIT;
         cnt_q      <= '0;
         conflict_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         conflict_q <= (state_q == RAM_READY) && wr_conflict;
      end
   end

   // NOTE: the array has no reset branch; it stays plain RAM and is cleared
   // entry by entry by the INIT sweep, which scales to any DEPTH.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int a = 0; a < DEPTH; a++) begin
            if (state_q == RAM_INIT) begin
               if (cnt_q == CW'(a)) begin
                  ram[a] <= INIT_VAL;
               end
            end else if (wr_en[a]) begin
               ram[a] <= wr_data[a];
            end
         end
      end
   end

   // Outputs are forced to their idle values while reset is held, so a reset
   // raised in READY hides stale contents from the very first cycle.
   assign ready = (state_q == RAM_READY) && !reset;

   always_comb begin
      rdata = {NRD{INIT_VAL}};
      for (int r = 0; r < NRD; r++) begin
         if (ready) begin
            for (int a = 0; a < DEPTH; a++) begin
               if (bus.raddr_i[r] == INDEX'(a)) begin
                  rdata[r] = ((BYPASS != 0) && wr_en[a]) ? wr_data[a] : ram[a];
               end
            end
         end
      end
   end

   assign bus.rdata_o    = rdata;
   assign bus.ready_o    = ready;
   assign bus.conflict_o = conflict_q && !reset;

endmodule

// File: tb/tb_ram_mrmw_init.sv
// Scoreboard bench for ram_mrmw_init: three instances (DEPTH 16 without and
// with bypass, DEPTH 12 with a non-zero INIT_VAL) driven by directed vectors.
module tb_ram_mrmw_init;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ram_mrmw_init_if #(.NRD(2), .NWR(2), .INDEX(4), .WIDTH(8)) ifa ();
   ram_mrmw_init_if #(.NRD(2), .NWR(2), .INDEX(4), .WIDTH(8)) ifb ();
   ram_mrmw_init_if #(.NRD(2), .NWR(2), .INDEX(4), .WIDTH(8)) ifc ();

   // The bypass instance sees exactly the same stimulus as instance a.
   assign ifb.raddr_i = ifa.raddr_i;
   assign ifb.waddr_i = ifa.waddr_i;
   assign ifb.wdata_i = ifa.wdata_i;
   assign ifb.we_i    = ifa.we_i;

   ram_mrmw_init #(.NRD(2), .NWR(2), .DEPTH(16), .INDEX(4), .WIDTH(8),
                   .BYPASS(0), .INIT_VAL(8'h00))
      u_a (.clk(clk), .reset(reset), .bus(ifa));

   ram_mrmw_init #(.NRD(2), .NWR(2), .DEPTH(16), .INDEX(4), .WIDTH(8),
                   .BYPASS(1), .INIT_VAL(8'h00))
      u_b (.clk(clk), .reset(reset), .bus(ifb));

   ram_mrmw_init #(.NRD(2), .NWR(2), .DEPTH(12), .INDEX(4), .WIDTH(8),
                   .BYPASS(0), .INIT_VAL(8'hE7))
      u_c (.clk(clk), .reset(reset), .bus(ifc));

   localparam int RD  = 0;
   localparam int RDY = 1;
   localparam int CFL = 2;

   typedef struct {
      int          cyc;
      int          dut;
      int          what;
      int          port;
      logic [7:0]  want;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   function automatic logic [7:0] sample(input int dut, input int what, input int port);
      logic [7:0] rd_v;
      logic       rdy_v;
      logic       cfl_v;
      if (dut == 0) begin
         rd_v = ifa.rdata_o[port]; rdy_v = ifa.ready_o; cfl_v = ifa.conflict_o;
      end else if (dut == 1) begin
         rd_v = ifb.rdata_o[port]; rdy_v = ifb.ready_o; cfl_v = ifb.conflict_o;
      end else begin
         rd_v = ifc.rdata_o[port]; rdy_v = ifc.ready_o; cfl_v = ifc.conflict_o;
      end
      if (what == RD)  return rd_v;
      if (what == RDY) return {7'd0, rdy_v};
      return {7'd0, cfl_v};
   endfunction

   task automatic check(input exp_t e);
      logic [7:0] got;
      got = sample(e.dut, e.what, e.port);
      checks++;
      if (got !== e.want) begin
         errors++;
         $display("FAIL %s (dut %0d port %0d cycle %0d): got %h, expected %h",
                  e.name, e.dut, e.port, e.cyc, got, e.want);
      end
   endtask

   // Monitor: outputs are sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         check(sb.pop_front());
      end
   end

   task automatic push_exp(input int dut, input int what, input int port,
                           input logic [7:0] want, input string name);
      sb.push_back('{cyc, dut, what, port, want, name});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ifa.we_i = '0;
      ifc.we_i = '0;
   endtask

   task automatic wr(input int dut, input int port, input int addr, input logic [7:0] data);
      if (dut == 0) begin
         ifa.we_i[port] = 1'b1; ifa.waddr_i[port] = 4'(addr); ifa.wdata_i[port] = data;
      end else begin
         ifc.we_i[port] = 1'b1; ifc.waddr_i[port] = 4'(addr); ifc.wdata_i[port] = data;
      end
   endtask

   task automatic rd(input int dut, input int port, input int addr);
      if (dut == 0) ifa.raddr_i[port] = 4'(addr);
      else          ifc.raddr_i[port] = 4'(addr);
   endtask

   // k counts cycles since reset was released; READY appears after k posedges
   // equal to DEPTH, i.e. in cycle 16 for a/b and cycle 12 for c.
   task automatic run_init(input int last_k, input int rst_k, input bit first);
      for (int k = 0; k <= last_k; k++) begin
         idle();
         rd(0, 0, k % 16); rd(0, 1, 15 - (k % 16));
         rd(2, 0, k % 12); rd(2, 1, 11 - (k % 12));
         if (k == rst_k) begin
            reset = 1'b1;
            step();
            return;
         end
         if (first && k == 5) begin
            wr(0, 0, 3, 8'hAA); wr(0, 1, 3, 8'hBB);
            wr(2, 0, 3, 8'hAA); wr(2, 1, 3, 8'hBB);
         end
         if (first && k == 16) wr(0, 0, 9, 8'h99);
         push_exp(0, RDY, 0, {7'd0, (k == 16)}, "ready_a");
         push_exp(1, RDY, 0, {7'd0, (k == 16)}, "ready_b");
         push_exp(2, RDY, 0, {7'd0, (k >= 12)}, "ready_c");
         push_exp(0, RD, 0, 8'h00, "init_rd_a");
         push_exp(2, RD, 1, 8'hE7, "init_rd_c");
         if (first && k == 6) begin
            push_exp(0, CFL, 0, 8'h00, "conflict_in_init_a");
            push_exp(2, CFL, 0, 8'h00, "conflict_in_init_c");
         end
         step();
      end
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      ifa.raddr_i = '0; ifa.waddr_i = '0; ifa.wdata_i = '0; ifa.we_i = '0;
      ifc.raddr_i = '0; ifc.waddr_i = '0; ifc.wdata_i = '0; ifc.we_i = '0;
      step();

      push_exp(0, RDY, 0, 8'h00, "rst_ready_a");
      push_exp(0, CFL, 0, 8'h00, "rst_conflict_a");
      push_exp(0, RD,  0, 8'h00, "rst_rd_a");
      push_exp(2, RD,  0, 8'hE7, "rst_rd_c");
      step();

      reset = 1'b0;
      run_init(16, -1, 1'b1);

      // Cycle 17: conflicting writes on a/b; out-of-range pair on c.
      idle();
      rd(0, 0, 3); rd(0, 1, 9);
      wr(0, 0, 3, 8'h11); wr(0, 1, 3, 8'h22);
      push_exp(0, RD, 0, 8'h00, "init_write_ignored_a");
      push_exp(0, RD, 1, 8'h99, "write_on_ready_edge_a");
      push_exp(0, CFL, 0, 8'h00, "single_write_no_conflict_a");
      push_exp(1, RD, 0, 8'h22, "bypass_winner_b");
      push_exp(1, RD, 1, 8'h99, "write_on_ready_edge_b");
      rd(2, 0, 13); rd(2, 1, 3);
      wr(2, 0, 13, 8'h12); wr(2, 1, 13, 8'h34);
      push_exp(2, RD, 0, 8'hE7, "oob_read_c");
      push_exp(2, RD, 1, 8'hE7, "init_write_ignored_c");
      step();

      // Cycle 18: conflict result; distinct-address writes.
      idle();
      rd(0, 0, 3); rd(0, 1, 7);
      wr(0, 0, 2, 8'h5A); wr(0, 1, 7, 8'hA5);
      push_exp(0, RD, 0, 8'h22, "conflict_winner_a");
      push_exp(0, CFL, 0, 8'h01, "conflict_pulse_a");
      push_exp(1, CFL, 0, 8'h01, "conflict_pulse_b");
      push_exp(0, RD, 1, 8'h00, "no_bypass_a");
      push_exp(1, RD, 1, 8'hA5, "bypass_port1_b");
      rd(2, 0, 13); rd(2, 1, 1);
      wr(2, 0, 11, 8'h4B); wr(2, 1, 12, 8'h55);
      push_exp(2, CFL, 0, 8'h00, "oob_no_conflict_c");
      push_exp(2, RD, 0, 8'hE7, "oob_dropped_c");
      push_exp(2, RD, 1, 8'hE7, "oob_no_alias1_c");
      step();

      // Cycle 19: both distinct writes landed, conflict already cleared.
      idle();
      rd(0, 0, 2); rd(0, 1, 7);
      push_exp(0, RD, 0, 8'h5A, "dual_write_p0_a");
      push_exp(0, RD, 1, 8'hA5, "dual_write_p1_a");
      push_exp(0, CFL, 0, 8'h00, "distinct_no_conflict_a");
      push_exp(1, CFL, 0, 8'h00, "distinct_no_conflict_b");
      rd(2, 0, 11); rd(2, 1, 0);
      push_exp(2, RD, 0, 8'h4B, "last_entry_c");
      push_exp(2, RD, 1, 8'hE7, "oob_no_alias0_c");
      push_exp(2, CFL, 0, 8'h00, "mixed_no_conflict_c");
      step();

      // Cycle 20: read-during-write on addr 4; valid conflict on c.
      idle();
      rd(0, 0, 4); rd(0, 1, 2);
      wr(0, 1, 4, 8'h3C);
      push_exp(0, RD, 0, 8'h00, "rdw_old_a");
      push_exp(1, RD, 0, 8'h3C, "rdw_new_b");
      push_exp(0, RD, 1, 8'h5A, "hold_addr2_a");
      rd(2, 0, 12);
      wr(2, 0, 6, 8'h01); wr(2, 1, 6, 8'h02);
      push_exp(2, RD, 0, 8'hE7, "oob12_read_c");
      step();

      // Cycle 21: write visible; disabled port sharing an address.
      idle();
      rd(0, 0, 4);
      push_exp(0, RD, 0, 8'h3C, "rdw_next_a");
      push_exp(1, RD, 0, 8'h3C, "rdw_next_b");
      wr(0, 0, 5, 8'h66);
      ifa.waddr_i[1] = 4'd5; ifa.wdata_i[1] = 8'h77;
      rd(2, 0, 6);
      push_exp(2, CFL, 0, 8'h01, "conflict_c");
      push_exp(2, RD, 0, 8'h02, "conflict_winner_c");
      step();

      // Cycle 22
      idle();
      rd(0, 0, 5);
      push_exp(0, RD, 0, 8'h66, "disabled_port_ignored_a");
      push_exp(0, CFL, 0, 8'h00, "disabled_no_conflict_a");
      push_exp(2, CFL, 0, 8'h00, "conflict_clears_c");
      step();

      // Reset in READY after the array was filled.
      reset = 1'b1;
      idle();
      step();
      push_exp(0, RDY, 0, 8'h00, "rst_in_ready_a");
      push_exp(0, CFL, 0, 8'h00, "rst_in_ready_conflict_a");
      push_exp(0, RD, 0, 8'h00, "rst_in_ready_rd_a");
      push_exp(2, RDY, 0, 8'h00, "rst_in_ready_c");
      push_exp(2, RD, 0, 8'hE7, "rst_in_ready_rd_c");
      step();

      // Release, then reset again at INIT cycle 6.
      reset = 1'b0;
      run_init(16, 6, 1'b0);
      push_exp(0, RDY, 0, 8'h00, "rst_mid_init_a");
      push_exp(2, RDY, 0, 8'h00, "rst_mid_init_c");
      step();

      reset = 1'b0;
      run_init(16, -1, 1'b0);

      // Every entry must hold INIT_VAL again.
      for (int a = 0; a < 16; a++) begin
         idle();
         rd(0, 0, a); rd(0, 1, 15 - a);
         rd(2, 0, a % 12);
         push_exp(0, RD, 0, 8'h00, "sweep_p0_a");
         push_exp(0, RD, 1, 8'h00, "sweep_p1_a");
         push_exp(1, RD, 0, 8'h00, "sweep_p0_b");
         push_exp(2, RD, 0, 8'hE7, "sweep_p0_c");
         if (a == 0) push_exp(0, RDY, 0, 8'h01, "ready_after_reinit_a");
         step();
      end

      for (int i = 0; i < 8 && sb.size() != 0; i++) step();
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left uncompared, expected 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
